// File: rtl/unpack_pkg.sv
// Shared types and helpers for the unpack receive buffer.
// Default geometry plus popcount / exclusive-prefix rank helpers.
package unpack_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned DEPTH  = 16;

  // Helpers accept masks zero-extended to MAX_N lanes.
  localparam int unsigned MAX_N  = 64;
  localparam int unsigned CNT_W  = 7;

  typedef logic [$clog2(LANES):0]   idx_t;
  typedef logic [$clog2(DEPTH)-1:0] ptr_t;
  typedef logic [$clog2(DEPTH):0]   occ_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [MAX_N-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_N; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  // Number of set bits strictly below position i.
  function automatic logic [CNT_W-1:0] rank_excl(input logic [MAX_N-1:0] v,
                                                 input int unsigned      i);
    logic [MAX_N-1:0] below;
    below = (MAX_N'(1) << i) - MAX_N'(1);
    return popcnt(v & below);
  endfunction

endpackage

// File: rtl/unpack_rank.sv
// Combinational lane ranker: per-lane exclusive prefix count of a mask
// and the total number of set lanes.
module unpack_rank
  import unpack_pkg::*;
#(
  parameter int unsigned N = LANES
) (
  input  logic [N-1:0]                       i_mask,
  output logic [N-1:0][$clog2(N):0]          o_rank,
  output logic [$clog2(N):0]                 o_total
);

  localparam int unsigned IW = $clog2(N) + 1;

  always_comb begin
    o_rank = '0;
    for (int i = 0; i < N; i++) begin
      o_rank[i] = IW'(rank_excl(MAX_N'(i_mask), i));
    end
    o_total = IW'(popcnt(MAX_N'(i_mask)));
  end

endmodule

// File: rtl/unpack.sv
// Receive-side lane unpacker: contiguous packed vectors go into a circular
// entry buffer and are scattered in arrival order onto requested lanes.
module unpack
  import unpack_pkg::*;
#(
  parameter int unsigned N = LANES,
  parameter int unsigned W = LANE_W,
  parameter int unsigned D = DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              in_vld_w,
  input  logic [N-1:0][W-1:0]       in_w,
  output logic                      in_rdy,
  input  logic [N-1:0]              out_req,
  output logic [N-1:0][W-1:0]       out_r,
  output logic [N-1:0]              out_vld_r,
  output logic [$clog2(D):0]        occ_r
);

  localparam int unsigned PW = $clog2(D);
  localparam int unsigned OW = PW + 1;
  localparam int unsigned IW = $clog2(N) + 1;

  if (N < 2 || N > MAX_N || D < N || (D & (D - 1)) != 0) begin : g_bad_cfg
    $error("unpack: illegal lane/depth configuration");
  end

  logic [W-1:0]           r_buf [D];
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [OW-1:0]          r_occ;

  logic [N-1:0][IW-1:0]   w_in_rank;
  logic [IW-1:0]          w_in_tot;
  logic [N-1:0][IW-1:0]   w_out_rank;
  logic [IW-1:0]          w_out_tot;
  logic                   w_push;
  logic                   w_grant;
  logic [OW-1:0]          w_add;
  logic [OW-1:0]          w_sub;

  unpack_rank #(.N(N)) u_rank_in (
    .i_mask  (in_vld_w),
    .o_rank  (w_in_rank),
    .o_total (w_in_tot)
  );

  unpack_rank #(.N(N)) u_rank_out (
    .i_mask  (out_req),
    .o_rank  (w_out_rank),
    .o_total (w_out_tot)
  );

  // Readiness depends only on held occupancy, never on this cycle's pop.
  assign in_rdy  = (OW'(D) - r_occ) >= OW'(N);
  assign w_push  = (|in_vld_w) && in_rdy;
  assign w_grant = (|out_req) && (OW'(w_out_tot) <= r_occ);
  assign w_add   = w_push  ? OW'(w_in_tot)  : '0;
  assign w_sub   = w_grant ? OW'(w_out_tot) : '0;
  assign occ_r   = r_occ;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      out_vld_r <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + PW'(w_add);
      r_rd_ptr  <= r_rd_ptr + PW'(w_sub);
      r_occ     <= r_occ + w_add - w_sub;
      out_vld_r <= w_grant ? out_req : '0;
    end
  end

  // Entry storage: data only, written at wr_ptr + lane rank.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      for (int i = 0; i < N; i++) begin
        if (in_vld_w[i]) r_buf[r_wr_ptr + PW'(w_in_rank[i])] <= in_w[i];
      end
    end
  end

  // Granted lanes load their ranked entry; other lanes hold.
  always_ff @(posedge clk) begin
    if (!rst && w_grant) begin
      for (int i = 0; i < N; i++) begin
        if (out_req[i]) out_r[i] <= r_buf[r_rd_ptr + PW'(w_out_rank[i])];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ((in_vld_w & (in_vld_w + N'(1))) == '0)
        else $error("unpack: non-contiguous input valid mask");
      assert (!(|in_vld_w) || in_rdy)
        else $error("unpack: push while not ready, vector dropped");
      assert (r_occ <= OW'(D))
        else $error("unpack: occupancy above depth");
    end
  end

endmodule

// File: tb/tb_unpack.sv
// Self-checking bench for unpack: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_unpack;

  localparam int unsigned N = 8;
  localparam int unsigned W = 32;
  localparam int unsigned D = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         in_vld_w;
  logic [N-1:0][W-1:0]  in_w;
  logic                 in_rdy;
  logic [N-1:0]         out_req;
  logic [N-1:0][W-1:0]  out_r;
  logic [N-1:0]         out_vld_r;
  logic [4:0]           occ_r;

  always #5 clk = ~clk;

  unpack #(.N(N), .W(W), .D(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld_w  (in_vld_w),
    .in_w      (in_w),
    .in_rdy    (in_rdy),
    .out_req   (out_req),
    .out_r     (out_r),
    .out_vld_r (out_vld_r),
    .occ_r     (occ_r)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_out   [N];
  logic        m_known [N];
  logic [7:0]  m_vld;
  logic [31:0] tag      = 32'd1;
  logic [31:0] tag_step = 32'd1;

  typedef struct {
    logic [7:0]  vld;
    logic [7:0]  req;
    logic [7:0]  e_vld;
    logic [4:0]  e_occ;
    logic        e_rdy;
    logic        ca;
    logic [2:0]  la;
    logic [31:0] da;
    logic        cb;
    logic [2:0]  lb;
    logic [31:0] db;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, advance the model, compare at next negedge.
  task automatic step(input logic [7:0] vld, input logic [7:0] req, input logic do_rst);
    int  k;
    int  m;
    bit  rdy_pre;
    k = $countones(vld);
    m = $countones(req);
    rdy_pre = (D - q.size()) >= N;
    rst      = do_rst;
    in_vld_w = vld;
    out_req  = req;
    for (int i = 0; i < N; i++) begin
      if (i < k) begin
        in_w[i] = tag;
        tag     = tag + tag_step;
      end else begin
        in_w[i] = $urandom;
      end
    end
    if (do_rst) begin
      q.delete();
      m_vld = 8'h00;
    end else begin
      if (m != 0 && m <= q.size()) begin
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            m_out[i]   = q.pop_front();
            m_known[i] = 1'b1;
          end
        end
        m_vld = req;
      end else begin
        m_vld = 8'h00;
      end
      if (k != 0 && rdy_pre) begin
        for (int i = 0; i < k; i++) q.push_back(in_w[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_vld_r", 32'(out_vld_r), 32'(m_vld));
    chk("occ_r", 32'(occ_r), 32'(q.size()));
    chk("in_rdy", 32'(in_rdy), 32'((D - q.size()) >= N));
    for (int i = 0; i < N; i++) begin
      if (m_known[i]) chk($sformatf("out_r[%0d]", i), out_r[i], m_out[i]);
    end
  endtask

  function automatic logic [7:0] low_mask(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  r;
    logic [31:0] t0;
    bit          pushed;
    int          k;

    rst = 1'b1; in_vld_w = '0; out_req = '0; in_w = '0;
    for (int i = 0; i < N; i++) begin m_known[i] = 1'b0; m_out[i] = '0; end
    m_vld = 8'h00;

    // Reset state
    step(8'h00, 8'h00, 1'b1);
    step(8'h00, 8'h00, 1'b1);
    chk("reset in_rdy", 32'(in_rdy), 32'd1);
    chk("reset occ_r", 32'(occ_r), 32'd0);
    chk("reset out_vld_r", 32'(out_vld_r), 32'h00);

    // Directed table: scatter, all-or-nothing refusal, held rd pointer
    tbl[0] = '{8'h07, 8'h00, 8'h00, 5'd3, 1'b1, 1'b0, 3'd0, 32'h0,  1'b0, 3'd0, 32'h0};
    tbl[1] = '{8'h00, 8'hA0, 8'hA0, 5'd1, 1'b1, 1'b1, 3'd5, 32'h11, 1'b1, 3'd7, 32'h22};
    tbl[2] = '{8'h00, 8'h0E, 8'h00, 5'd1, 1'b1, 1'b1, 3'd5, 32'h11, 1'b0, 3'd0, 32'h0};
    tbl[3] = '{8'h00, 8'h01, 8'h01, 5'd0, 1'b1, 1'b1, 3'd0, 32'h33, 1'b1, 3'd7, 32'h22};
    tag = 32'h11; tag_step = 32'h11;
    for (int v = 0; v < 4; v++) begin
      step(tbl[v].vld, tbl[v].req, 1'b0);
      chk($sformatf("tbl%0d out_vld_r", v), 32'(out_vld_r), 32'(tbl[v].e_vld));
      chk($sformatf("tbl%0d occ_r", v), 32'(occ_r), 32'(tbl[v].e_occ));
      chk($sformatf("tbl%0d in_rdy", v), 32'(in_rdy), 32'(tbl[v].e_rdy));
      if (tbl[v].ca) chk($sformatf("tbl%0d lane a", v), out_r[tbl[v].la], tbl[v].da);
      if (tbl[v].cb) chk($sformatf("tbl%0d lane b", v), out_r[tbl[v].lb], tbl[v].db);
    end
    tag = 32'h1000; tag_step = 32'd1;

    // Backpressure at occupancy 9, second full push only once ready
    step(8'h00, 8'h00, 1'b1);
    step(8'h01, 8'h00, 1'b0);
    step(8'hFF, 8'h00, 1'b0);
    chk("bp occ 9", 32'(occ_r), 32'd9);
    chk("bp rdy low", 32'(in_rdy), 32'd0);
    pushed = 1'b0;
    for (int c = 0; c < 10 && !pushed; c++) begin
      if (!in_rdy) step(8'h00, 8'h01, 1'b0);
      else begin
        step(8'hFF, 8'h00, 1'b0);
        pushed = 1'b1;
      end
    end
    chk("bp second push", 32'(pushed), 32'd1);
    chk("bp occ full", 32'(occ_r), 32'd16);
    chk("bp rdy full", 32'(in_rdy), 32'd0);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      step(8'h00, low_mask(q.size() > 8 ? 8 : q.size()), 1'b0);
    end
    chk("bp drained", 32'(occ_r), 32'd0);

    // Steady push 3 / pop 3 with wrapping pointers
    step(8'h00, 8'h00, 1'b1);
    step(8'h07, 8'h00, 1'b0);
    for (int c = 0; c < 40; c++) begin
      r = 8'h00;
      while ($countones(r) < 3) r[$urandom_range(7, 0)] = 1'b1;
      step(8'h07, r, 1'b0);
      chk("steady occ", 32'(occ_r), 32'd3);
      chk("steady vld", 32'(out_vld_r), 32'(r));
    end

    // Reset during a grant discards contents
    step(8'h00, 8'h00, 1'b1);
    step(8'h1F, 8'h00, 1'b0);
    chk("rst occ 5", 32'(occ_r), 32'd5);
    step(8'h00, 8'h03, 1'b1);
    chk("rst mid occ", 32'(occ_r), 32'd0);
    chk("rst mid vld", 32'(out_vld_r), 32'h00);
    chk("rst mid rdy", 32'(in_rdy), 32'd1);
    t0 = tag;
    step(8'h07, 8'h00, 1'b0);
    step(8'h00, 8'h07, 1'b0);
    chk("rst fresh lane0", out_r[0], t0);
    chk("rst fresh vld", 32'(out_vld_r), 32'h07);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      k = in_rdy ? int'($urandom_range(8, 0)) : 0;
      step(low_mask(k), 8'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
